uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

- Shares one 8N1 UART transmitter between NUM_REQ requesters, serialising whole frames.
- A requester holds the grant from its first byte until the byte flagged last has completed on the line; then arbitration reopens.
- Sits between the transmitter and the data sources. It drives the transmitter's data_valid/data_in inputs and consumes its one-cycle done pulse.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- PTR_W, $clog2(NUM_REQ), width of the round-robin pointer and grant index
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester byte available
- req_data  in  8*NUM_REQ  flattened bytes; requester i on bits [8i+7:8i]
- req_last  in  NUM_REQ  byte presented by requester i is the last of its frame
- req_ready  out  NUM_REQ  one-hot accept strobe; byte i taken when req_valid[i] & req_ready[i]
- grant  out  NUM_REQ  one-hot current owner; all-zero when unowned
- tx_data_valid  out  1  start strobe to transmitter
- tx_data_out  out  8  byte to transmitter
- tx_done  in  1  transmitter stop-bit-complete pulse
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, SEND, WAIT, HOLD (2-bit encoding).
- IDLE
  - No req_valid: remain in IDLE.
  - Any req_valid: pick winner g. req_ready[g]=1 combinationally that cycle.
  - Latch req_data[g] into the data register and req_last[g] into last_q. Set the grant register to g. Go to SEND.
- SEND
  - tx_data_valid=1 for exactly one cycle. tx_data_out = data register.
  - Go to WAIT.
- WAIT
  - Hold the data register.
  - On tx_done: if last_q, clear grant, update pointer, go to IDLE; else go to HOLD.
- HOLD
  - Grant stays on g. Only requester g may be accepted; others ignored.
  - On req_valid[g]: req_ready[g]=1, latch byte and last flag, go to SEND.
  - No req_valid[g]: wait indefinitely. There is no timeout; frame completion is the requester's obligation.
- Requester rule: req_data and req_last stable while req_valid high until the ready strobe.
- tx_done outside WAIT is ignored.
- req_ready is zero in SEND and WAIT.
- Pointer update at frame end: ptr <= (g+1) mod NUM_REQ. Wrap from NUM_REQ-1 to 0 required.

## Timing
- Reset values: state IDLE, grant 0, req_ready 0, tx_data_valid 0, tx_data_out 8'h00, busy 0, ptr 0, last_q 0.
- Accept cycle N (req_ready high) -> tx_data_valid high in cycle N+1.
- tx_done sampled in cycle M:
  - State is IDLE or HOLD in M+1.
  - Earliest next accept is M+1; tx_data_valid no earlier than M+2.
  - This matches the transmitter returning to its idle state one cycle after done.
- Single-byte frame (req_last=1 on first byte): IDLE->SEND->WAIT->IDLE.
- Grant changes only on leaving WAIT with last_q=1, or on entering SEND from IDLE.
- Reset mid-frame: immediately returns to reset values. The frame is abandoned; no partial-frame resume.
- busy rises in the cycle after acceptance in IDLE, and falls in the cycle after the final tx_done.

## Configuration
- UART_TX_ARB_ROUND_ROBIN_EN defined: winner is the first requester with req_valid set, scanning upward from ptr and wrapping.
- Not defined: fixed priority; lowest asserted index wins. ptr is held at 0 and unused.

## Structure
- Package uart_arb_pkg holds:
  - state localparams IDLE=0, SEND=1, WAIT=2, HOLD=3;
  - BYTE_W=8;
  - function onehot_to_index.
- One sub-module, uart_arb_picker: purely combinational. Inputs are the req vector and ptr; output is a one-hot winner plus a found flag. The fixed/round-robin choice is made inside it.
- The top holds the state register, data/last/grant/pointer registers and the output decode.

## Test plan
- Single byte: req_valid=4'b0010, data 8'hA5, last=1 -> req_ready=4'b0010 for one cycle; tx_data_valid one cycle later with tx_data_out=8'hA5; busy drops the cycle after tx_done.
- Frame lock: req 0 sends 3 bytes (last on byte 3) while req 2 is held valid throughout -> req 0's 3 bytes go out contiguously; req 2 is granted only after the third tx_done.
- Round robin (macro on): all four valid with last=1, looping -> grant order 0,1,2,3,0. With macro off -> grant stays 0 while req 0 is valid.
- Pointer wrap (macro on): after req 3 completes, req 0 and req 3 both valid -> req 0 wins.
- Spurious done: tx_done pulsed in IDLE and in HOLD -> no state change, no pointer change.
- Reset mid-frame: assert reset during WAIT of byte 2 of a 4-byte frame -> all outputs at reset values next cycle; a new request afterwards is granted normally.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
//   Shared definitions for the UART transmit arbiter slice.
//   - FSM state encodings (2-bit, legacy-compatible constants)
//   - BYTE_W: width of one UART data byte
//   - onehot_to_index: converts an up-to-8-bit one-hot vector to its index
package uart_arb_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam int BYTE_W = 8;

  // OR-combining is exact for a one-hot input; all-zero maps to 0.
  function automatic logic [2:0] onehot_to_index(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_arb_picker.sv
// uart_arb_picker
//   Purely combinational winner selection for the UART transmit arbiter.
//   Build option: UART_TX_ARB_ROUND_ROBIN_EN
//     defined   - scan upward from ptr, wrapping, first asserted request wins
//     undefined - fixed priority, lowest asserted index wins (ptr ignored)
//   Ports:
//     req    in  NUM_REQ  request vector
//     ptr    in  PTR_W    round-robin start index
//     winner out NUM_REQ  one-hot winner (all-zero when nothing requested)
//     found  out 1        at least one request asserted
module uart_arb_picker
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               found
);

`ifdef UART_TX_ARB_ROUND_ROBIN_EN
  always_comb begin
    logic [PTR_W-1:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req[k]) begin
        winner[k] = 1'b1;
        found     = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one 8N1 UART transmitter between NUM_REQ requesters. A requester
//   keeps the grant from its first byte until the byte flagged last has been
//   reported done by the transmitter; arbitration then reopens.
//   Build option: UART_TX_ARB_ROUND_ROBIN_EN (round-robin when defined,
//   fixed lowest-index priority otherwise).
//   Ports:
//     clk           in   1          system clock, rising edge
//     reset         in   1          asynchronous active-high reset
//     req_valid     in   NUM_REQ    per-requester byte available
//     req_data      in   8*NUM_REQ  requester i on bits [8i+7:8i]
//     req_last      in   NUM_REQ    presented byte ends requester i's frame
//     req_ready     out  NUM_REQ    one-hot accept strobe
//     grant         out  NUM_REQ    one-hot current owner, zero when unowned
//     tx_data_valid out  1          start strobe to transmitter
//     tx_data_out   out  8          byte to transmitter
//     tx_done       in   1          transmitter frame-complete pulse
//     busy          out  1          high whenever not IDLE
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      tx_data_valid,
  output logic [BYTE_W-1:0]         tx_data_out,
  input  logic                      tx_done,
  output logic                      busy
);

  logic [1:0]         state_q;
  logic [BYTE_W-1:0]  data_q;
  logic               last_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_next;

  logic [NUM_REQ-1:0] winner;
  logic               found;
  logic               take;
  logic [BYTE_W-1:0]  sel_data;
  logic               sel_last;

  uart_arb_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req    (req_valid),
    .ptr    (ptr_q),
    .winner (winner),
    .found  (found)
  );

  // Ready is forced low while reset is held so all outputs sit at their
  // reset values even if requesters keep req_valid asserted.
  always_comb begin
    req_ready = '0;
    if (!reset) begin
      case (state_q)
        IDLE:    req_ready = found ? winner : '0;
        HOLD:    req_ready = grant_q & req_valid;
        default: req_ready = '0;
      endcase
    end
  end

  assign take = |req_ready;

  // req_ready is one-hot, so an AND-OR mux selects the accepted byte.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sel_data = sel_data | (req_data[BYTE_W*i +: BYTE_W] & {BYTE_W{req_ready[i]}});
      sel_last = sel_last | (req_last[i] & req_ready[i]);
    end
  end

`ifdef UART_TX_ARB_ROUND_ROBIN_EN
  logic [7:0] grant_ext;
  logic [2:0] grant_idx;

  always_comb begin
    grant_ext                = '0;
    grant_ext[NUM_REQ-1:0]   = grant_q;
    grant_idx                = onehot_to_index(grant_ext);
    ptr_next                 = PTR_W'((32'(grant_idx) + 32'd1) % NUM_REQ);
  end
`else
  assign ptr_next = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      last_q  <= 1'b0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take) begin
            data_q  <= sel_data;
            last_q  <= sel_last;
            grant_q <= req_ready;
            state_q <= SEND;
          end
        end
        SEND: state_q <= WAIT;
        WAIT: begin
          if (tx_done) begin
            if (last_q) begin
              grant_q <= '0;
              ptr_q   <= ptr_next;
              state_q <= IDLE;
            end else begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (take) begin
            data_q  <= sel_data;
            last_q  <= sel_last;
            state_q <= SEND;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant         = grant_q;
  assign tx_data_valid = (state_q == SEND);
  assign tx_data_out   = data_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        tx_data_valid;
  logic [7:0]  tx_data_out;
  logic        tx_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .PTR_W(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .grant         (grant),
    .tx_data_valid (tx_data_valid),
    .tx_data_out   (tx_data_out),
    .tx_done       (tx_done),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transmitter model: one-cycle done pulse sampled on the next edge.
  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_txv"},   32'(tx_data_valid), 32'h0);
    chk({tag, "_txd"},   32'(tx_data_out), 32'h00);
    chk({tag, "_busy"},  32'(busy), 32'h0);
  endtask

  logic [3:0] rr_exp [4];
  logic [7:0] rr_dat [4];

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b0;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100; rr_exp[3] = 4'b1000;
    rr_dat[0] = 8'h40;   rr_dat[1] = 8'h41;   rr_dat[2] = 8'h42;   rr_dat[3] = 8'h43;
`else
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0001; rr_exp[2] = 4'b0001; rr_exp[3] = 4'b0001;
    rr_dat[0] = 8'h40;   rr_dat[1] = 8'h40;   rr_dat[2] = 8'h40;   rr_dat[3] = 8'h40;
`endif
    tick(); tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();

    // Single-byte frame from requester 1
    req_data[15:8] = 8'hA5; req_last = 4'b0010; req_valid = 4'b0010; #1;
    chk("t1_ready", 32'(req_ready), 32'h2);
    chk("t1_busy_pre", 32'(busy), 32'h0);
    tick(); req_valid = '0; #1;
    chk("t1_txv", 32'(tx_data_valid), 32'h1);
    chk("t1_txd", 32'(tx_data_out), 32'hA5);
    chk("t1_grant", 32'(grant), 32'h2);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_ready_send", 32'(req_ready), 32'h0);
    tick(); #1;
    chk("t1_txv_wait", 32'(tx_data_valid), 32'h0);
    chk("t1_busy_wait", 32'(busy), 32'h1);
    pulse_done();
    chk("t1_busy_after", 32'(busy), 32'h0);
    chk("t1_grant_after", 32'(grant), 32'h0);

    // Frame lock: requester 0 sends 3 bytes while requester 2 waits
    req_data[7:0] = 8'h11; req_last = 4'b0000; req_valid = 4'b0001; #1;
    chk("t2_ready1", 32'(req_ready), 32'h1);
    tick();
    req_data[7:0] = 8'h22; req_data[23:16] = 8'h2C; req_last = 4'b0100; req_valid = 4'b0101; #1;
    chk("t2_txd1", 32'(tx_data_out), 32'h11);
    chk("t2_grant1", 32'(grant), 32'h1);
    tick(); #1;
    chk("t2_ready_wait1", 32'(req_ready), 32'h0);
    pulse_done();
    chk("t2_ready_hold1", 32'(req_ready), 32'h1);
    chk("t2_busy_hold1", 32'(busy), 32'h1);
    tick();
    req_data[7:0] = 8'h33; req_last = 4'b0101; #1;
    chk("t2_txd2", 32'(tx_data_out), 32'h22);
    chk("t2_txv2", 32'(tx_data_valid), 32'h1);
    tick(); #1;
    pulse_done();
    chk("t2_ready_hold2", 32'(req_ready), 32'h1);
    tick(); req_valid = 4'b0100; #1;
    chk("t2_txd3", 32'(tx_data_out), 32'h33);
    chk("t2_grant3", 32'(grant), 32'h1);
    tick(); #1;
    chk("t2_ready_wait3", 32'(req_ready), 32'h0);
    pulse_done();
    chk("t2_grant_idle", 32'(grant), 32'h0);
    chk("t2_ready_req2", 32'(req_ready), 32'h4);
    tick(); req_valid = '0; #1;
    chk("t2_grant2", 32'(grant), 32'h4);
    chk("t2_txd_req2", 32'(tx_data_out), 32'h2C);
    tick(); #1;
    pulse_done();

    // Return pointer to 0 before the arbitration order test
    reset = 1'b1; #1;
    chk("rst2_busy", 32'(busy), 32'h0);
    tick(); reset = 1'b0; #1;

    // All four valid, single-byte frames
    req_data = 32'h43424140; req_last = 4'b1111; req_valid = 4'b1111;
    for (int f = 0; f < 4; f++) begin
      #1;
      chk($sformatf("t3_ready%0d", f), 32'(req_ready), 32'(rr_exp[f]));
      tick(); #1;
      chk($sformatf("t3_grant%0d", f), 32'(grant), 32'(rr_exp[f]));
      chk($sformatf("t3_txd%0d", f), 32'(tx_data_out), 32'(rr_dat[f]));
      tick(); #1;
      pulse_done();
    end

    // Pointer wrap: 0 and 3 valid after requester 3 completed
    req_valid = 4'b1001; #1;
    chk("t4_ready_wrap", 32'(req_ready), 32'h1);
    tick(); #1;
    chk("t4_grant_wrap", 32'(grant), 32'h1);
    tick(); #1;
    pulse_done();
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
    chk("t4_ready_next", 32'(req_ready), 32'h8);
`else
    chk("t4_ready_next", 32'(req_ready), 32'h1);
`endif
    tick(); req_valid = '0; #1;
    tick(); #1;
    pulse_done();

    // Spurious done in IDLE
    tx_done = 1'b1; tick(); tx_done = 1'b0; #1;
    chk("t5_idle_busy", 32'(busy), 32'h0);
    chk("t5_idle_txv", 32'(tx_data_valid), 32'h0);
    // Two-byte frame from requester 1, spurious done while in HOLD
    req_data[15:8] = 8'h5A; req_last = 4'b0000; req_valid = 4'b0010; #1;
    chk("t5_ready1", 32'(req_ready), 32'h2);
    tick(); req_valid = '0; #1;
    tick(); #1;
    pulse_done();
    chk("t5_hold_ready", 32'(req_ready), 32'h0);
    tx_done = 1'b1; tick(); tx_done = 1'b0; #1;
    chk("t5_hold_busy", 32'(busy), 32'h1);
    chk("t5_hold_grant", 32'(grant), 32'h2);
    chk("t5_hold_txv", 32'(tx_data_valid), 32'h0);
    tick(); #1;
    chk("t5_hold_busy2", 32'(busy), 32'h1);
    req_data[15:8] = 8'h5B; req_last = 4'b0010; req_valid = 4'b0010; #1;
    chk("t5_ready2", 32'(req_ready), 32'h2);
    tick(); req_valid = '0; #1;
    chk("t5_txd2", 32'(tx_data_out), 32'h5B);
    tick(); #1;
    pulse_done();
    chk("t5_busy_end", 32'(busy), 32'h0);
    req_last = 4'b1001; req_valid = 4'b1001; #1;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
    chk("t5_ptr_ready", 32'(req_ready), 32'h8);
`else
    chk("t5_ptr_ready", 32'(req_ready), 32'h1);
`endif
    tick(); req_valid = '0; #1;
    tick(); #1;
    pulse_done();

    // Reset during WAIT of byte 2 of a 4-byte frame from requester 2
    req_data[23:16] = 8'hC1; req_last = 4'b0000; req_valid = 4'b0100; #1;
    chk("t6_ready1", 32'(req_ready), 32'h4);
    tick(); req_data[23:16] = 8'hC2; #1;
    tick(); #1;
    pulse_done();
    chk("t6_ready2", 32'(req_ready), 32'h4);
    tick(); #1;
    chk("t6_txd2", 32'(tx_data_out), 32'hC2);
    tick(); #1;
    reset = 1'b1; #1;
    chk_reset_vals("t6_rst");
    tick();
    chk_reset_vals("t6_rst_hold");
    reset = 1'b0; req_valid = '0;
    tick();
    req_data[15:8] = 8'h77; req_last = 4'b0010; req_valid = 4'b0010; #1;
    chk("t6_new_ready", 32'(req_ready), 32'h2);
    tick(); req_valid = '0; #1;
    chk("t6_new_grant", 32'(grant), 32'h2);
    chk("t6_new_txd", 32'(tx_data_out), 32'h77);
    chk("t6_new_txv", 32'(tx_data_valid), 32'h1);
    tick(); #1;
    pulse_done();
    chk("t6_new_busy", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
